// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the hardwired zero-register index and the port-slice index helper.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned ZERO_REG  = 0;

   // LSB position of port 'port' inside a flattened bus of 'width'-bit fields.
   function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for regfile_mp. One pending bit per register:
// a reserve sets it, a write-back clears it, and a reserve beats a
// same-cycle write because the newly issued producer supersedes the old one.
// Bit 0 is never set. When RF_BYPASS_EN is defined, rd_busy is
// forced low for a read that matches a same-cycle write.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   logic [DEPTH-1:0]  pending_r;
   logic [DEPTH-1:0]  pending_nxt_s;
   logic [ADDR_W-1:0] wr_a_s;
   logic [ADDR_W-1:0] rd_a_s;

   // Next pending state: writes release, then a reserve re-marks; r0 stays clear.
   always_comb begin
      pending_nxt_s = pending_r;
      wr_a_s        = {ADDR_W{1'b0}};
      for (int unsigned w = 0; w < NUM_WR; w++) begin
         wr_a_s                = wr_addr[port_lsb(w, ADDR_W) +: ADDR_W];
         pending_nxt_s[wr_a_s] = wr_en[w] ? 1'b0 : pending_nxt_s[wr_a_s];
      end
      pending_nxt_s[rsv_addr] = rsv_en ? 1'b1 : pending_nxt_s[rsv_addr];
      pending_nxt_s[0]        = 1'b0;
   end

   // Pending-bit register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r <= {DEPTH{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Busy lookup per read port, optionally released by a same-cycle write.
   always_comb begin
      rd_busy = {NUM_RD{1'b0}};
      rd_a_s  = {ADDR_W{1'b0}};
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_a_s     = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
         rd_busy[p] = pending_r[rd_a_s];
`ifdef RF_BYPASS_EN
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            rd_busy[p] = (wr_en[w] &&
                          (wr_addr[port_lsb(w, ADDR_W) +: ADDR_W] == rd_a_s) &&
                          (rd_a_s != ADDR_W'(ZERO_REG))) ? 1'b0 : rd_busy[p];
         end
`endif
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with pending-write scoreboard.
// NUM_RD combinational read ports, NUM_WR clocked write ports where the
// higher-indexed port wins on an address collision, r0 hardwired to zero.
// Optional feature macro: RF_BYPASS_EN -- same-cycle write-to-read
// forwarding of data and busy release (higher write port wins).
module regfile_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [ADDR_W-1:0] rd_a_s;
   logic [DATA_W-1:0] rd_v_s;

   // Register storage: ports applied in ascending order so the higher port wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[port_lsb(w, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
               mem_r[wr_addr[port_lsb(w, ADDR_W) +: ADDR_W]] <= wr_data[port_lsb(w, DATA_W) +: DATA_W];
            end
         end
      end
   end

   // Combinational read muxes with zero-register forcing and optional bypass.
   always_comb begin
      rd_data = {(NUM_RD*DATA_W){1'b0}};
      rd_a_s  = {ADDR_W{1'b0}};
      rd_v_s  = {DATA_W{1'b0}};
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_a_s = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
         rd_v_s = (rd_a_s == ADDR_W'(ZERO_REG)) ? {DATA_W{1'b0}} : mem_r[rd_a_s];
`ifdef RF_BYPASS_EN
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            rd_v_s = (wr_en[w] &&
                      (wr_addr[port_lsb(w, ADDR_W) +: ADDR_W] == rd_a_s) &&
                      (rd_a_s != ADDR_W'(ZERO_REG))) ? wr_data[port_lsb(w, DATA_W) +: DATA_W] : rd_v_s;
         end
`endif
         rd_data[port_lsb(p, DATA_W) +: DATA_W] = rd_v_s;
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

endmodule
